// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: per-register latency countdown, operand source select and RAW/WAW stall.
// Define FWD_SCOREBOARD_PERF_EN to build the saturating stall_cycles performance counter.
module fwd_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int LAT_W        = 3,
    parameter int RA_IDX       = 1,
    localparam int REG_W       = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_RD_PORTS*REG_W-1:0] rs,
    input  logic [NUM_RD_PORTS-1:0]       rs_valid,
    input  logic                          wr_en,
    input  logic [REG_W-1:0]              wr_rd,
    input  logic                          write_ra_en,
    input  logic                          issue_valid,
    input  logic [REG_W-1:0]              issue_rd,
    input  logic [LAT_W-1:0]              issue_lat,
    input  logic                          flush,
    output logic [NUM_RD_PORTS*2-1:0]     src_sel,
    output logic                          stall,
    output logic [31:0]                   stall_cycles
);

    typedef enum logic [1:0] {
        SEL_RF_OUT = 2'd0,
        SEL_RF_IN  = 2'd1,
        SEL_MAGIC  = 2'd2
    } sel_e;

    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
    localparam logic [REG_W-1:0] RA_REG  = REG_W'(RA_IDX);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];

    logic [REG_W-1:0] rs_p;
    sel_e             sel_p;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             issue_accept;

    // Source select and RAW detection per read port.
    always_comb begin
        raw_hazard = 1'b0;
        src_sel    = '0;
        rs_p       = '0;
        sel_p      = SEL_RF_OUT;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rs_p  = rs[p*REG_W +: REG_W];
            sel_p = SEL_RF_OUT;
            if (rs_p == '0) begin
                sel_p = SEL_RF_OUT;
            end else if (write_ra_en && (rs_p == RA_REG)) begin
                sel_p = SEL_MAGIC;
            end else if ((wr_en && (wr_rd == rs_p)) || (cnt_q[rs_p] == LAT_ONE)) begin
                sel_p = SEL_RF_IN;
            end
            src_sel[p*2 +: 2] = sel_p;
            if (rs_valid[p] && (rs_p != '0) && (cnt_q[rs_p] > LAT_ONE)) begin
                raw_hazard = 1'b1;
            end
        end
    end

    // A destination on the write port this cycle (cnt==1) may be reissued without waiting.
    assign waw_hazard   = issue_valid && (issue_rd != '0) && (cnt_q[issue_rd] > LAT_ONE);
    assign stall        = reset && (raw_hazard || waw_hazard);
    assign issue_accept = issue_valid && !stall && (issue_rd != '0) && (issue_lat != '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_ONE) : '0;
        end
        if (issue_accept) begin
            cnt_d[issue_rd] = issue_lat;
        end
        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_d[r] = '0;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: latency countdown, forwarding priority, RAW/WAW stall, flush, reset.
module tb_fwd_scoreboard;

    localparam int REG_W = 5;

`ifdef FWD_SCOREBOARD_PERF_EN
    localparam logic [31:0] PERF_AFTER4 = 32'd4;
`else
    localparam logic [31:0] PERF_AFTER4 = 32'd0;
`endif

    logic             clk;
    logic             reset;
    logic [2*REG_W-1:0] rs;
    logic [1:0]       rs_valid;
    logic             wr_en;
    logic [REG_W-1:0] wr_rd;
    logic             write_ra_en;
    logic             issue_valid;
    logic [REG_W-1:0] issue_rd;
    logic [2:0]       issue_lat;
    logic             flush;
    logic [3:0]       src_sel;
    logic             stall;
    logic [31:0]      stall_cycles;

    int tests = 0;
    int fails = 0;

    fwd_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .rs           (rs),
        .rs_valid     (rs_valid),
        .wr_en        (wr_en),
        .wr_rd        (wr_rd),
        .write_ra_en  (write_ra_en),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .flush        (flush),
        .src_sel      (src_sel),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change 1ns after the rising edge, checks 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs          = '0;
        rs_valid    = '0;
        wr_en       = 1'b0;
        wr_rd       = '0;
        write_ra_en = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_lat   = '0;
        flush       = 1'b0;
    endtask

    task automatic set_rs(input logic [REG_W-1:0] r0, input logic [REG_W-1:0] r1,
                          input logic [1:0] v);
        rs       = {r1, r0};
        rs_valid = v;
    endtask

    task automatic issue(input logic [REG_W-1:0] rd, input logic [2:0] lat);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_lat   = lat;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        step();
        step();
        reset = 1'b1;
        #1;

        // Reset state: nothing pending, all selects RF_OUT
        set_rs(5'd5, 5'd9, 2'b11);
        #1;
        check("rst_src_sel", 32'(src_sel), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_stall_cycles", stall_cycles, 32'h0);
        step();

        // Four RAW stall cycles, then count check, then reset clears the counter
        idle();
        issue(5'd5, 3'd5);
        #1;
        check("perf_issue_stall", 32'(stall), 32'h0);
        step();
        idle();
        set_rs(5'd5, 5'd0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("perf_raw_stall_%0d", i), 32'(stall), 32'h1);
            step();
        end
        idle();
        set_rs(5'd5, 5'd0, 2'b00);
        #1;
        check("perf_cnt1_src", 32'(src_sel), 32'h1);
        check("perf_count4", stall_cycles, PERF_AFTER4);
        step();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("perf_count_cleared", stall_cycles, 32'h0);

        // rd=5 lat=3: stall at t+1, t+2; RF_IN at t+3; RF_OUT at t+4
        idle();
        issue(5'd5, 3'd3);
        step();
        idle();
        set_rs(5'd5, 5'd0, 2'b01);
        #1;
        check("lat3_t1_stall", 32'(stall), 32'h1);
        step();
        check("lat3_t2_stall", 32'(stall), 32'h1);
        step();
        check("lat3_t3_stall", 32'(stall), 32'h0);
        check("lat3_t3_src", 32'(src_sel[1:0]), 32'h1);
        step();
        check("lat3_t4_src", 32'(src_sel[1:0]), 32'h0);
        check("lat3_t4_stall", 32'(stall), 32'h0);
        step();

        // Write-through forwarding, port1 on r0
        idle();
        wr_en = 1'b1;
        wr_rd = 5'd7;
        set_rs(5'd7, 5'd0, 2'b11);
        #1;
        check("wt_src_sel", 32'(src_sel), 32'h1);
        check("wt_stall", 32'(stall), 32'h0);
        step();

        // Magic Ra beats write-through; without magic write-through wins
        idle();
        write_ra_en = 1'b1;
        wr_en       = 1'b1;
        wr_rd       = 5'd1;
        set_rs(5'd1, 5'd1, 2'b11);
        #1;
        check("magic_src_sel", 32'(src_sel), 32'hA);
        write_ra_en = 1'b0;
        #1;
        check("magic_off_src_sel", 32'(src_sel), 32'h5);
        step();

        // WAW: rd=9 lat=4, retry rd=9 lat=2 stalls until cnt[9]==1
        idle();
        issue(5'd9, 3'd4);
        step();
        issue(5'd9, 3'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("waw_stall_%0d", i), 32'(stall), 32'h1);
            step();
        end
        set_rs(5'd9, 5'd0, 2'b01);
        #1;
        check("waw_retry_stall", 32'(stall), 32'h0);
        check("waw_retry_src", 32'(src_sel[1:0]), 32'h1);
        step();
        idle();
        set_rs(5'd9, 5'd0, 2'b01);
        #1;
        check("waw_reload_stall", 32'(stall), 32'h1);
        step();
        check("waw_reload_src", 32'(src_sel[1:0]), 32'h1);
        check("waw_reload_nostall", 32'(stall), 32'h0);
        step();
        check("waw_done_src", 32'(src_sel[1:0]), 32'h0);
        step();

        // Flush at t+2 discards rd=3 lat=5
        idle();
        issue(5'd3, 3'd5);
        step();
        idle();
        step();
        flush = 1'b1;
        set_rs(5'd3, 5'd0, 2'b01);
        #1;
        check("flush_cycle_stall", 32'(stall), 32'h1);
        step();
        flush = 1'b0;
        #1;
        check("post_flush_stall", 32'(stall), 32'h0);
        check("post_flush_src", 32'(src_sel[1:0]), 32'h0);
        step();

        // Flush overrides a simultaneous issue
        idle();
        issue(5'd4, 3'd3);
        flush = 1'b1;
        step();
        idle();
        set_rs(5'd4, 5'd0, 2'b01);
        #1;
        check("flush_vs_issue_stall", 32'(stall), 32'h0);
        step();

        // Zero latency and r0 destinations create no entry
        idle();
        issue(5'd8, 3'd0);
        step();
        idle();
        set_rs(5'd8, 5'd0, 2'b01);
        #1;
        check("lat0_stall", 32'(stall), 32'h0);
        check("lat0_src", 32'(src_sel[1:0]), 32'h0);
        step();
        idle();
        issue(5'd0, 3'd5);
        step();
        issue(5'd0, 3'd5);
        set_rs(5'd0, 5'd0, 2'b11);
        #1;
        check("rd0_stall", 32'(stall), 32'h0);
        check("rd0_src", 32'(src_sel), 32'h0);
        step();

        // Maximum latency: six stall cycles then RF_IN
        idle();
        issue(5'd10, 3'd7);
        step();
        idle();
        set_rs(5'd10, 5'd10, 2'b10);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("maxlat_stall_%0d", i), 32'(stall), 32'h1);
            step();
        end
        check("maxlat_stall_end", 32'(stall), 32'h0);
        check("maxlat_src", 32'(src_sel), 32'h5);
        step();

        // Reset mid-operation forces stall low and discards pending entries
        idle();
        issue(5'd6, 3'd7);
        step();
        idle();
        set_rs(5'd6, 5'd0, 2'b01);
        reset = 1'b0;
        #1;
        check("rst_forces_stall", 32'(stall), 32'h0);
        step();
        reset = 1'b1;
        #1;
        check("rst_discard_stall", 32'(stall), 32'h0);
        check("rst_discard_src", 32'(src_sel[1:0]), 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
